// File: rtl/tinker_mem_pkg.sv
// Shared constants and response record for the tinker data memory.
package tinker_mem_pkg;
  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_DEPTH      = 524288;
  localparam int DEF_DATA_BYTES = 8;
  localparam int DEF_LAT        = 2;
  localparam int DEF_RSP_DEPTH  = 4;
  localparam int DEF_ALIGN_CHK  = 1;

  localparam int MAX_DATA_W = 64;

  typedef struct packed {
    logic                  err;
    logic [MAX_DATA_W-1:0] rdata;
  } rsp_t;
endpackage

// File: rtl/tinker_rsp_fifo.sv
// Response FIFO with valid/ready on both sides.
// When empty, an incoming entry is presented at the output in the same cycle.
module tinker_rsp_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             empty;
  logic             bypass;
  logic             push;
  logic             pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty     = (count == '0);
  assign in_ready  = (count < CNT_W'(DEPTH));
  assign out_valid = !empty || in_valid;
  assign out_data  = !empty ? store[rd_ptr] : (in_valid ? in_data : '0);
  assign bypass    = empty && in_valid && out_ready;
  assign push      = in_valid && in_ready && !bypass;
  assign pop       = !empty && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) store[wr_ptr] <= in_data;
  end
endmodule

// File: rtl/tinker_data_mem.sv
// Byte-addressed data memory with a fetch port and a pipelined, credit-limited
// request/response data port.
module tinker_data_mem
  import tinker_mem_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int DATA_BYTES = DEF_DATA_BYTES,
  parameter int LAT        = DEF_LAT,
  parameter int RSP_DEPTH  = DEF_RSP_DEPTH,
  parameter int ALIGN_CHK  = DEF_ALIGN_CHK
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_W-1:0]       if_addr,
  output logic [31:0]             if_data,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [8*DATA_BYTES-1:0] req_wdata,
  input  logic [DATA_BYTES-1:0]   req_be,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [8*DATA_BYTES-1:0] rsp_rdata,
  output logic                    rsp_err
);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int DATA_W = 8 * DATA_BYTES;
  localparam int CNT_W  = $clog2(RSP_DEPTH + 1);

  logic [7:0]        mem [DEPTH];
  logic              accept;
  logic              pop;
  logic [CNT_W-1:0]  credit;
  logic [ADDR_W:0]   req_end;
  logic [ADDR_W:0]   if_end;
  logic              req_oob;
  logic              req_mis;
  logic              req_err;
  logic [IDX_W-1:0]  req_idx;
  logic [IDX_W-1:0]  if_idx;
  logic [DATA_W-1:0] load_data;
  rsp_t              new_rsp;
  logic              pipe_valid [LAT];
  rsp_t              pipe_rsp   [LAT];
  logic              fifo_in_ready;
  rsp_t              head;

  assign accept    = req_valid && req_ready;
  assign pop       = rsp_valid && rsp_ready;
  assign req_ready = (credit < CNT_W'(RSP_DEPTH));

  assign req_idx = req_addr[IDX_W-1:0];
  assign req_end = {1'b0, req_addr} + (ADDR_W+1)'(DATA_BYTES);
  assign req_oob = (req_end > (ADDR_W+1)'(DEPTH));
  assign req_mis = (ALIGN_CHK != 0) && ((req_addr % ADDR_W'(DATA_BYTES)) != '0);
  assign req_err = req_oob || req_mis;

  assign if_idx = if_addr[IDX_W-1:0];
  assign if_end = {1'b0, if_addr} + (ADDR_W+1)'(4);

  // Loads see the array as it stands in the accept cycle.
  always_comb begin
    load_data = '0;
    for (int i = 0; i < DATA_BYTES; i++) begin
      load_data[8*i +: 8] = mem[req_idx + IDX_W'(i)];
    end
  end

  always_comb begin
    new_rsp.err   = req_err;
    new_rsp.rdata = (req_we || req_err) ? '0 : MAX_DATA_W'(load_data);
  end

  always_ff @(posedge clk) begin
    if (accept && req_we && !req_err) begin
      for (int i = 0; i < DATA_BYTES; i++) begin
        if (req_be[i]) mem[req_idx + IDX_W'(i)] <= req_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_data <= '0;
    end else if (if_end > (ADDR_W+1)'(DEPTH)) begin
      if_data <= '0;
    end else begin
      if_data <= {mem[if_idx + IDX_W'(3)], mem[if_idx + IDX_W'(2)],
                  mem[if_idx + IDX_W'(1)], mem[if_idx]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < LAT; k++) begin
        pipe_valid[k] <= 1'b0;
        pipe_rsp[k]   <= '0;
      end
    end else begin
      pipe_valid[0] <= accept;
      pipe_rsp[0]   <= new_rsp;
      for (int k = 1; k < LAT; k++) begin
        pipe_valid[k] <= pipe_valid[k-1];
        pipe_rsp[k]   <= pipe_rsp[k-1];
      end
    end
  end

  // Credits cover pipeline plus FIFO, so the FIFO can never be full on arrival.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credit <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   credit <= credit + 1'b1;
        2'b01:   credit <= credit - 1'b1;
        default: credit <= credit;
      endcase
    end
  end

  tinker_rsp_fifo #(
    .WIDTH($bits(rsp_t)),
    .DEPTH(RSP_DEPTH)
  ) u_rsp_fifo (
    .clk      (clk),
    .reset    (reset),
    .in_valid (pipe_valid[LAT-1]),
    .in_ready (fifo_in_ready),
    .in_data  (pipe_rsp[LAT-1]),
    .out_valid(rsp_valid),
    .out_ready(rsp_ready),
    .out_data (head)
  );

  assign rsp_rdata = head.rdata[DATA_W-1:0];
  assign rsp_err   = head.err;

  fifo_space_a: assert property (@(posedge clk) disable iff (reset)
    pipe_valid[LAT-1] |-> fifo_in_ready);
endmodule
